// File: rtl/cdb_issue_scheduler_pkg.sv
// rtl/cdb_issue_scheduler_pkg.sv - shared types and owner-ID helpers for the CDB issue scheduler
//
// Purpose: owner-ID storage type, the reservation slot struct and the
// functions that map a channel count onto the mult/div owner IDs.
// Owner IDs are stored at a fixed width wide enough for the largest legal
// channel count (8 single-cycle channels + mult + div = 10 IDs); the top
// narrows them to its own ID width when driving the CDB select.

package cdb_issue_scheduler_pkg;

  localparam int OWN_W = 4;

  typedef logic [OWN_W-1:0] owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rsv_slot_t;

  // Multiplier owns the ID just above the single-cycle channels.
  function automatic owner_t own_mult(input int num_1c);
    return owner_t'(num_1c);
  endfunction

  // Divider owns the ID just above the multiplier.
  function automatic owner_t own_div(input int num_1c);
    return owner_t'(num_1c + 1);
  endfunction

endpackage

// File: rtl/cdb_issue_scheduler_rr_arbiter.sv
// rtl/cdb_issue_scheduler_rr_arbiter.sv - round-robin arbiter for the single-cycle issue group
//
// Purpose: picks the first requesting channel at or after the pointer,
// wrapping around, and advances the pointer past the winner when the grant
// is actually taken.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointer -> 0)
//   req         request vector, one bit per channel
//   accept      the grant was used this cycle; move the pointer
//   gnt         one-hot (or zero) grant
//   gnt_idx     binary index of the granted channel (0 when none)

module cdb_issue_scheduler_rr_arbiter
  import cdb_issue_scheduler_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt,
  output owner_t       gnt_idx
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;

  // Two passes: channels at/after the pointer first, then the wrapped ones.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k] && (k >= int'(ptr_q))) begin
        gnt[k]  = 1'b1;
        gnt_idx = owner_t'(k);
        found   = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req[k] && (k < int'(ptr_q))) begin
        gnt[k]  = 1'b1;
        gnt_idx = owner_t'(k);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept && found) begin
      if (int'(gnt_idx) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = PTR_W'(int'(gnt_idx) + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cdb_issue_scheduler.sv
// rtl/cdb_issue_scheduler.sv - issue arbiter with CDB slot reservation for 1-cycle, mult and div units
//
// Purpose: grants at most one issue per cycle (div > mult > round-robin
// single-cycle group) such that no two results ever land on the CDB in the
// same cycle, using a shift register of future CDB slot reservations.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop every in-flight reservation; no issue this cycle
//   ready_1c     per single-cycle channel ready
//   ready_mult   multiplier queue ready
//   ready_div    divider queue ready
//   issue_1c     one-hot single-cycle grant
//   issue_mult   multiplier grant
//   issue_div    divider grant
//   div_busy     divider still working on an earlier op
//   cdb_valid    a result is broadcast this cycle
//   cdb_owner    CDB source select (0..NUM_1C-1 channel, NUM_1C mult, NUM_1C+1 div)

module cdb_issue_scheduler
  import cdb_issue_scheduler_pkg::*;
#(
  parameter int NUM_1C   = 2,
  parameter int MULT_LAT = 3,
  parameter int DIV_LAT  = 6,
  parameter int ID_W     = $clog2(NUM_1C + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NUM_1C-1:0] ready_1c,
  input  logic              ready_mult,
  input  logic              ready_div,
  output logic [NUM_1C-1:0] issue_1c,
  output logic              issue_mult,
  output logic              issue_div,
  output logic              div_busy,
  output logic              cdb_valid,
  output logic [ID_W-1:0]   cdb_owner
);

  localparam int     DCNT_W   = $clog2(DIV_LAT);
  localparam owner_t OWN_MULT = own_mult(NUM_1C);
  localparam owner_t OWN_DIV  = own_div(NUM_1C);

  generate
    if (NUM_1C < 1 || NUM_1C > 8 || MULT_LAT < 2 || MULT_LAT >= DIV_LAT) begin : g_bad_params
      $error("cdb_issue_scheduler: illegal NUM_1C/MULT_LAT/DIV_LAT combination");
    end
  endgenerate

  // rsv_q[i] describes the CDB i cycles from now.
  rsv_slot_t         rsv_q [DIV_LAT+1];
  rsv_slot_t         rsv_d [DIV_LAT+1];
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;

  logic              block;
  logic              elig_div, elig_mult;
  logic [NUM_1C-1:0] req_1c;
  logic [NUM_1C-1:0] gnt_1c;
  owner_t            gnt_idx;
  logic              grant_1c;

  // Issues are suppressed during reset as well as flush so that ready
  // inputs cannot leak through to the grant outputs while rst_n is low.
  assign block     = flush | ~rst_n;
  assign div_busy  = (dcnt_q != '0);
  assign elig_div  = ready_div && !div_busy && !rsv_q[DIV_LAT].valid;
  assign elig_mult = ready_mult && !rsv_q[MULT_LAT].valid;
  assign req_1c    = ready_1c & {NUM_1C{!rsv_q[1].valid}};

  assign issue_div  = elig_div && !block;
  assign issue_mult = elig_mult && !elig_div && !block;
  assign issue_1c   = gnt_1c & {NUM_1C{!elig_div && !elig_mult && !block}};
  assign grant_1c   = |issue_1c;

  assign cdb_valid = rsv_q[0].valid;
  assign cdb_owner = rsv_q[0].valid ? ID_W'(rsv_q[0].owner) : '0;

  cdb_issue_scheduler_rr_arbiter #(
    .N (NUM_1C)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_1c),
    .accept  (grant_1c),
    .gnt     (gnt_1c),
    .gnt_idx (gnt_idx)
  );

  // Shift first, then insert: a latency-L issue lands in slot L-1 because
  // the whole window moves one step at the same edge.
  always_comb begin
    for (int i = 0; i < DIV_LAT; i++) begin
      rsv_d[i] = rsv_q[i+1];
    end
    rsv_d[DIV_LAT] = '0;

    if (issue_div) begin
      rsv_d[DIV_LAT-1] = '{valid: 1'b1, owner: OWN_DIV};
    end
    if (issue_mult) begin
      rsv_d[MULT_LAT-1] = '{valid: 1'b1, owner: OWN_MULT};
    end
    if (grant_1c) begin
      rsv_d[0] = '{valid: 1'b1, owner: gnt_idx};
    end

    if (issue_div) begin
      dcnt_d = DCNT_W'(DIV_LAT - 1);
    end else if (dcnt_q != '0) begin
      dcnt_d = dcnt_q - DCNT_W'(1);
    end else begin
      dcnt_d = dcnt_q;
    end

    // The result already in slot 0 is on the bus this cycle and completes;
    // everything behind it is killed, including the divider's occupancy.
    if (flush) begin
      for (int i = 0; i <= DIV_LAT; i++) begin
        rsv_d[i] = '0;
      end
      dcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DIV_LAT; i++) begin
        rsv_q[i] <= '0;
      end
      dcnt_q <= '0;
    end else begin
      for (int i = 0; i <= DIV_LAT; i++) begin
        rsv_q[i] <= rsv_d[i];
      end
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// tb/tb_cdb_issue_scheduler.sv - self-checking bench for cdb_issue_scheduler

module tb_cdb_issue_scheduler;

  localparam int N   = 2;
  localparam int ML  = 3;
  localparam int DL  = 6;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic [N-1:0]   ready_1c;
  logic           ready_mult;
  logic           ready_div;
  logic [N-1:0]   issue_1c;
  logic           issue_mult;
  logic           issue_div;
  logic           div_busy;
  logic           cdb_valid;
  logic [IDW-1:0] cdb_owner;

  always #5 clk = ~clk;

  cdb_issue_scheduler #(
    .NUM_1C   (N),
    .MULT_LAT (ML),
    .DIV_LAT  (DL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .ready_1c   (ready_1c),
    .ready_mult (ready_mult),
    .ready_div  (ready_div),
    .issue_1c   (issue_1c),
    .issue_mult (issue_mult),
    .issue_div  (issue_div),
    .div_busy   (div_busy),
    .cdb_valid  (cdb_valid),
    .cdb_owner  (cdb_owner)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: CDB occupancy keyed by absolute cycle number.
  int sched[int];
  int mt;
  int rr;
  int div_free;

  // Last sampled DUT outputs, for scenario-specific checks.
  logic [N-1:0]   o_1c;
  logic           o_mult, o_div, o_busy, o_cv;
  logic [IDW-1:0] o_own;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, mt);
    end
  endtask

  task automatic model_reset();
    sched.delete();
    mt       = 0;
    rr       = 0;
    div_free = 0;
  endtask

  // Called at posedge+1; holds rst_n low for one cycle and checks outputs.
  task automatic do_reset(input logic [N-1:0] r1c, input logic rm, input logic rd);
    rst_n      = 1'b0;
    ready_1c   = r1c;
    ready_mult = rm;
    ready_div  = rd;
    flush      = 1'b0;
    #4;
    check("rst_issue_1c", issue_1c, 0);
    check("rst_issue_mult", issue_mult, 0);
    check("rst_issue_div", issue_div, 0);
    check("rst_div_busy", div_busy, 0);
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_owner", cdb_owner, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive at posedge+1, sample/compare at negedge, advance model.
  task automatic step(input logic [N-1:0] r1c, input logic rm, input logic rd, input logic fl);
    logic [N-1:0] e1c;
    logic         emul, ediv, ebusy, ecv;
    int           eown;
    int           gk;
    ready_1c   = r1c;
    ready_mult = rm;
    ready_div  = rd;
    flush      = fl;
    #4;
    o_1c   = issue_1c;
    o_mult = issue_mult;
    o_div  = issue_div;
    o_busy = div_busy;
    o_cv   = cdb_valid;
    o_own  = cdb_owner;

    ecv   = sched.exists(mt);
    eown  = ecv ? sched[mt] : 0;
    ebusy = (mt < div_free);
    e1c   = '0;
    emul  = 1'b0;
    ediv  = 1'b0;
    gk    = -1;
    if (!fl) begin
      if (rd && !ebusy && !sched.exists(mt + DL)) begin
        ediv = 1'b1;
      end else if (rm && !sched.exists(mt + ML)) begin
        emul = 1'b1;
      end else if (!sched.exists(mt + 1)) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (rr + i) % N;
          if (gk < 0 && ((r1c >> k) & 1) != 0) gk = k;
        end
        if (gk >= 0) e1c = N'(1) << gk;
      end
    end

    check("issue_1c", o_1c, e1c);
    check("issue_mult", o_mult, emul);
    check("issue_div", o_div, ediv);
    check("div_busy", o_busy, ebusy);
    check("cdb_valid", o_cv, ecv);
    check("cdb_owner", o_own, eown);

    if (fl) begin
      for (int c = mt + 1; c <= mt + DL; c++) begin
        if (sched.exists(c)) sched.delete(c);
      end
      if (div_free > mt + 1) div_free = mt + 1;
    end else if (ediv) begin
      sched[mt + DL] = N + 1;
      div_free = mt + DL;
    end else if (emul) begin
      sched[mt + ML] = N;
    end else if (gk >= 0) begin
      sched[mt + 1] = gk;
      rr = (gk + 1) % N;
    end
    if (sched.exists(mt)) sched.delete(mt);
    mt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    ready_1c   = '0;
    ready_mult = 1'b0;
    ready_div  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // All ready during reset; div wins first cycle, lands at t6.
    do_reset('1, 1'b1, 1'b1);
    for (int c = 0; c <= 6; c++) begin
      step('1, 1'b1, 1'b1, 1'b0);
      if (c == 0) check("t1_div_t0", o_div, 1);
      if (c == 6) begin
        check("t1_cv_t6", o_cv, 1);
        check("t1_own_t6", o_own, 3);
      end
    end

    // Back-to-back divides exactly DL apart.
    do_reset('0, 1'b0, 1'b1);
    for (int c = 0; c <= 12; c++) begin
      step('0, 1'b0, 1'b1, 1'b0);
      check("t2_div", o_div, (c == 0 || c == 6 || c == 12));
      if (c >= 1 && c <= 5) check("t2_busy", o_busy, 1);
    end

    // Round-robin alternation.
    do_reset('0, 1'b0, 1'b0);
    for (int c = 0; c <= 5; c++) begin
      step(2'b11, 1'b0, 1'b0, 1'b0);
      check("t3_1c", o_1c, (c % 2 == 1) ? 2 : 1);
      if (c >= 1) check("t3_own", o_own, (c - 1) % 2);
    end

    // Mult reservation blocks the single-cycle slot.
    do_reset('0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("t4_mult_t0", o_mult, 1);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    check("t4_1c_t2", o_1c, 0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    check("t4_1c_t3", o_1c, 1);
    check("t4_own_t3", o_own, 2);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("t4_cv_t4", o_cv, 1);
    check("t4_own_t4", o_own, 0);

    // Div reservation blocks mult until its slot frees.
    do_reset('0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("t5_mult_t3", o_mult, 0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    check("t5_mult_t4", o_mult, 1);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("t5_own_t6", o_own, 3);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("t5_own_t7", o_own, 2);

    // Flush kills the divide in flight.
    do_reset('0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1, 1'b0);
    check("t6_busy_t3", o_busy, 0);
    check("t6_div_t3", o_div, 1);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);
    check("t6_cv_t6", o_cv, 0);

    // Randomized traffic with occasional flush and reset.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset(N'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; c < 300; c++) begin
        step(N'($urandom), ($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 20) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
